record_unpacker_fifo: RTL and testbench
=======================================

// Module: record_unpacker_fifo
// PURPOSE
//  Synchronous FIFO for the return path: the inverse of the byte-in/record-out FIFO.
//  - Accepts one whole record (RecordWords words) per write.
//  - Emits one word per read.
//  - Sits between record producers (status/telemetry builders) and the byte-wide
//    serial transmitter, which drains data_out one word at a time.
// PARAMETERS
//  WordSize     8   bits per output word
//  RecordWords  16  words per record; power of 2
//  Depth        4   capacity in records; power of 2
//  Derived: RecordSizeBits = WordSize*RecordWords; StorageSize = Depth*RecordWords;
//           StoragePosSize = $clog2(StorageSize); RecordPosSize = $clog2(RecordWords)
// PORTS
//  clk          in   1                 clock; all state updates on rising edge
//  rst          in   1                 synchronous reset, active high
//  write_en     in   1                 request to enqueue data_in as one record
//  data_in      in   RecordSizeBits    record; word i = data_in[(i+1)*WordSize-1 : i*WordSize]
//  read_en      in   1                 request to dequeue one word
//  data_out     out  WordSize          word at read position; valid while !empty
//  record_last  out  1                 data_out is word RecordWords-1 of its record
//  full         out  1                 fewer than RecordWords free word slots
//  empty        out  1                 no words stored
//  size         out  StoragePosSize+1  words currently stored
//  overflow     out  1                 sticky: write_en seen while full
//  underflow    out  1                 sticky: read_en seen while empty
// BEHAVIOUR
//  Storage
//  - StorageSize x WordSize array; not reset.
//  - Pointers: write_pos and read_pos, each StoragePosSize+1 bits, free-running,
//    wrap modulo 2^(StoragePosSize+1).
//  - Array index = pointer[StoragePosSize-1:0].
//  Status
//  - size = write_pos - read_pos (modular).
//  - empty = (size == 0).
//  - full  = (size > StorageSize - RecordWords).
//  - All three are combinational from the registered pointers.
//  Write
//  - do_write = write_en & !full.
//  - On do_write, word i of data_in goes to index (write_pos + i) mod StorageSize,
//    for i = 0..RecordWords-1; then write_pos += RecordWords.
//  - write_pos always stays a multiple of RecordWords.
//  Read
//  - do_read = read_en & !empty.
//  - On do_read, read_pos += 1.
//  - data_out = storage[read_pos idx], combinational, zero latency.
//  - Word 0 of a record is emitted first.
//  - record_last = (read_pos[RecordPosSize-1:0] == RecordWords-1) & !empty.
//  Simultaneous events
//  - do_write and do_read in the same cycle both take effect.
//  - size changes by RecordWords-1.
//  - A write never overwrites the word being read: full guarantees the slot ranges
//    are disjoint.
//  - A read issued while empty is not satisfied by a write in the same cycle;
//    the new data appears on the next cycle.
//  Error flags
//  - overflow  sets on write_en & full;  the record is dropped, state is unchanged.
//  - underflow sets on read_en & empty;  read_pos is unchanged.
//  - Both flags hold until rst.
//  Reset
//  - rst has priority over write_en/read_en in the same cycle.
//  - Clears both pointers, overflow and underflow. After reset:
//    size=0, empty=1, full=0, record_last=0, overflow=0, underflow=0.
//  - data_out is don't-care while empty.
//  - Reset mid-record discards any partially drained record; no flush is needed.
// TESTING (defaults: W=8, RW=16, D=4)
//  1. rst, then one write of data_in = {8'h0F,...,8'h01,8'h00}
//     -> size=16 next cycle.
//     16 reads emit 00..0F in order; record_last=1 only on 0F; then empty=1, size=0.
//  2. 4 writes with no reads -> size=64, full=1.
//     5th write -> overflow=1, size stays 64.
//     1 read -> size=63, full still 1.
//     After 16 reads (size=48) -> full=0.
//  3. read_en on empty -> underflow=1, size=0, read_pos unchanged.
//     Flag remains 1 until rst.
//  4. With size=20: write_en and read_en in the same cycle -> size=35.
//     The reader's next word is the pre-existing one, not the new record.
//  5. Wrap: run 10 records with interleaved reads so the pointers pass the
//     64/128 boundaries -> output order exactly matches the scoreboard;
//     size never exceeds 64.
//  6. Assert rst after 5 words of a record have been read -> next cycle size=0,
//     empty=1. A fresh write then reads out from word 0.

Source files
------------

// File: rtl/record_unpacker_fifo.sv
// Record-in / word-out FIFO: each write stores one whole record, each read pops one word.
// Latency: a written record is visible on data_out the cycle after the write; reads are zero-latency.
// Backpressure: full blocks writes (the record is dropped and overflow is set); empty blocks reads (underflow is set).
//
// Ports:
//   clk, rst               clock; synchronous active-high reset
//   write_en, data_in      enqueue one record (word i = data_in[i*WordSize +: WordSize])
//   read_en                dequeue one word
//   data_out, record_last  current word and "last word of its record" marker
//   full, empty, size      occupancy status (combinational from the pointers)
//   overflow, underflow    sticky error flags, cleared only by rst
module record_unpacker_fifo #(
    parameter int WordSize    = 8,
    parameter int RecordWords = 16,
    parameter int Depth       = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  write_en,
    input  logic [WordSize*RecordWords-1:0]       data_in,
    input  logic                                  read_en,
    output logic [WordSize-1:0]                   data_out,
    output logic                                  record_last,
    output logic                                  full,
    output logic                                  empty,
    output logic [$clog2(Depth*RecordWords):0]    size,
    output logic                                  overflow,
    output logic                                  underflow
);

    localparam int StorageSize    = Depth * RecordWords;
    localparam int StoragePosSize = $clog2(StorageSize);
    localparam int RecordPosSize  = $clog2(RecordWords);

    // Pointers carry one extra bit so full and empty remain distinguishable.
    logic [StoragePosSize:0] write_pos;
    logic [StoragePosSize:0] read_pos;
    logic [WordSize-1:0]     mem [StorageSize];

    logic do_write;
    logic do_read;

    assign size     = write_pos - read_pos;
    assign empty    = (size == '0);
    // Full means there is no room for another whole record.
    assign full     = (size > (StoragePosSize+1)'(StorageSize - RecordWords));
    assign do_write = write_en & ~full;
    assign do_read  = read_en & ~empty;

    assign data_out    = mem[read_pos[StoragePosSize-1:0]];
    assign record_last = (read_pos[RecordPosSize-1:0] == RecordPosSize'(RecordWords - 1)) & ~empty;

    // write_pos is always record-aligned, so a record occupies one contiguous slot
    // range and never wraps inside the array. Because full leaves fewer than a record
    // of free slots blocked, that range is always disjoint from the word being read.
    always_ff @(posedge clk) begin
        if (do_write && !rst) begin
            for (int i = 0; i < RecordWords; i++) begin
                mem[write_pos[StoragePosSize-1:0] + StoragePosSize'(i)] <= data_in[i*WordSize +: WordSize];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            write_pos <= '0;
            read_pos  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (do_write) begin
                write_pos <= write_pos + (StoragePosSize+1)'(RecordWords);
            end
            if (do_read) begin
                read_pos <= read_pos + 1'b1;
            end
            if (write_en && full) begin
                overflow <= 1'b1;
            end
            if (read_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_record_unpacker_fifo.sv
// Bench for record_unpacker_fifo: directed scenarios plus randomized traffic, all
// checked every cycle against a queue-based model; directed literal checks pin the model.
// Stimulus is applied just after each rising edge; outputs are compared on falling edges.
module tb_record_unpacker_fifo;

    localparam int W  = 8;
    localparam int RW = 16;
    localparam int D  = 4;
    localparam int S  = D * RW;
    localparam int SP = $clog2(S);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              write_en = 1'b0;
    logic [W*RW-1:0]   data_in = '0;
    logic              read_en = 1'b0;
    logic [W-1:0]      data_out;
    logic              record_last;
    logic              full;
    logic              empty;
    logic [SP:0]       size;
    logic              overflow;
    logic              underflow;

    int checks = 0;
    int errors = 0;

    record_unpacker_fifo #(.WordSize(W), .RecordWords(RW), .Depth(D)) dut (
        .clk(clk), .rst(rst),
        .write_en(write_en), .data_in(data_in),
        .read_en(read_en), .data_out(data_out),
        .record_last(record_last), .full(full), .empty(empty), .size(size),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [W-1:0] m_q[$];
    int           m_reads = 0;   // words popped since reset
    bit           m_ovf = 0;
    bit           m_unf = 0;
    bit           model_live = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_reads = 0;
            m_ovf   = 0;
            m_unf   = 0;
            model_live = 1;
        end else if (model_live) begin
            bit was_full;
            bit was_empty;
            was_full  = (m_q.size() > S - RW);
            was_empty = (m_q.size() == 0);
            if (write_en && was_full)  m_ovf = 1;
            if (read_en  && was_empty) m_unf = 1;
            // Pop before push: a read on empty is never served by the same-cycle write.
            if (read_en && !was_empty) begin
                void'(m_q.pop_front());
                m_reads++;
            end
            if (write_en && !was_full) begin
                for (int i = 0; i < RW; i++) m_q.push_back(data_in[i*W +: W]);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (model_live && !rst) begin
            chk("cyc_size", int'(size), m_q.size());
            chk("cyc_empty", int'(empty), int'(m_q.size() == 0));
            chk("cyc_full", int'(full), int'(m_q.size() > S - RW));
            chk("cyc_overflow", int'(overflow), int'(m_ovf));
            chk("cyc_underflow", int'(underflow), int'(m_unf));
            chk("cyc_record_last", int'(record_last),
                int'(m_q.size() != 0 && (m_reads % RW) == RW - 1));
            chk("cyc_size_le_cap", int'(int'(size) <= S), 1);
            if (m_q.size() != 0) chk("cyc_data_out", int'(data_out), int'(m_q[0]));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step_d(input bit r, input bit we, input logic [W*RW-1:0] din, input bit re);
        rst      = r;
        write_en = we;
        data_in  = din;
        read_en  = re;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        write_en = 1'b0;
        read_en  = 1'b0;
    endtask

    function automatic logic [W*RW-1:0] rec(input int base);
        logic [W*RW-1:0] d;
        for (int i = 0; i < RW; i++) d[i*W +: W] = W'(base + i);
        return d;
    endfunction

    task automatic do_reset();
        step_d(1'b1, 1'b0, '0, 1'b0);
    endtask

    task automatic wr(input int base);
        step_d(1'b0, 1'b1, rec(base), 1'b0);
    endtask

    task automatic rd(input int n);
        for (int i = 0; i < n; i++) step_d(1'b0, 1'b0, '0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // Reset state.
        chk("rst_size", int'(size), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_record_last", int'(record_last), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_underflow", int'(underflow), 0);

        // 1. One record 00..0F, drained in order.
        wr(8'h00);
        chk("t1_size16", int'(size), 16);
        for (int i = 0; i < RW; i++) begin
            chk("t1_word", int'(data_out), i);
            chk("t1_last", int'(record_last), int'(i == RW - 1));
            rd(1);
        end
        chk("t1_empty", int'(empty), 1);
        chk("t1_size0", int'(size), 0);

        // 2. Fill to capacity, overflow, drain below threshold.
        for (int r = 0; r < D; r++) wr(8'h10 * (r + 1));
        chk("t2_size64", int'(size), 64);
        chk("t2_full", int'(full), 1);
        wr(8'hF0);
        chk("t2_overflow", int'(overflow), 1);
        chk("t2_size_kept", int'(size), 64);
        rd(1);
        chk("t2_size63", int'(size), 63);
        chk("t2_full63", int'(full), 1);
        rd(15);
        chk("t2_size48", int'(size), 48);
        chk("t2_full48", int'(full), 0);
        chk("t2_ovf_sticky", int'(overflow), 1);

        // 3. Underflow; same-cycle write does not satisfy the read.
        do_reset();
        rd(1);
        chk("t3_underflow", int'(underflow), 1);
        chk("t3_size0", int'(size), 0);
        step_d(1'b0, 1'b1, rec(8'h30), 1'b1);
        chk("t3_size16", int'(size), 16);
        chk("t3_word0", int'(data_out), 8'h30);
        chk("t3_unf_sticky", int'(underflow), 1);
        do_reset();
        chk("t3_unf_cleared", int'(underflow), 0);

        // 4. Simultaneous write and read with 20 words stored.
        wr(8'h40);
        wr(8'h60);
        rd(12);
        chk("t4_size20", int'(size), 20);
        chk("t4_pre_word", int'(data_out), 8'h4C);
        step_d(1'b0, 1'b1, rec(8'h80), 1'b1);
        chk("t4_size35", int'(size), 35);
        chk("t4_next_old", int'(data_out), 8'h4D);

        // 6. Reset mid-record (with requests asserted alongside reset).
        do_reset();
        wr(8'hA0);
        rd(5);
        chk("t6_word5", int'(data_out), 8'hA5);
        step_d(1'b1, 1'b1, rec(8'hB0), 1'b1);
        chk("t6_size0", int'(size), 0);
        chk("t6_empty", int'(empty), 1);
        chk("t6_last0", int'(record_last), 0);
        wr(8'hC0);
        chk("t6_fresh_word0", int'(data_out), 8'hC0);
        chk("t6_fresh_last", int'(record_last), 0);

        // 5. Randomized traffic; pointers wrap many times. Checked by the per-cycle compare.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            logic [W*RW-1:0] d;
            for (int k = 0; k < RW; k++) d[k*W +: W] = W'($urandom);
            step_d(1'b0, ($urandom_range(0, 7) < 2), d, ($urandom_range(0, 3) != 0));
        end
        for (int c = 0; c < S + 2; c++) rd(1);
        chk("t5_drained", int'(empty), 1);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
